// File: rtl/llc_req_arbiter.sv
// Two-client round-robin arbiter (CPU LLC = client 0, USB DMA = client 1) onto one
// downstream read/write request port. Optional timeout abort: define LLC_ARB_TIMEOUT_EN.
module llc_req_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              cl_rd_req,
    input  logic [1:0]              cl_wr_req,
    input  logic [2*ADDR_WIDTH-1:0] cl_addr,
    input  logic [2*DATA_WIDTH-1:0] cl_wdata,
    output logic [DATA_WIDTH-1:0]   cl_rdata,
    output logic [1:0]              cl_done,
    output logic [1:0]              cl_err,
    output logic                    busy,
    output logic                    read_request,
    output logic                    write_request,
    output logic [ADDR_WIDTH-1:0]   write_address,
    output logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    axi_valid,
    input  logic                    axi_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e                  state_q, state_d;
    logic                    g_q, g_d;
    logic                    op_wr_q, op_wr_d;
    logic                    last_grant_q, last_grant_d;
    logic                    rd_req_q, rd_req_d;
    logic                    wr_req_q, wr_req_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              done_q, done_d;

    logic [1:0]              pending;
    logic                    grant_idx;
    logic                    done_hit;
    logic                    timeout_hit;

`ifdef LLC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              err_q, err_d;
`endif

    assign pending = cl_rd_req | cl_wr_req;
    // On a tie the client that did not win last time takes the grant.
    assign grant_idx = (pending == 2'b11) ? ~last_grant_q : pending[1];
    // Only the strobe matching the issued operation counts as completion.
    assign done_hit  = op_wr_q ? axi_ready : axi_valid;

`ifdef LLC_ARB_TIMEOUT_EN
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !done_hit;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pending) state_d = ISSUE;
            ISSUE:   if (done_hit || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        g_d          = g_q;
        op_wr_d      = op_wr_q;
        last_grant_d = last_grant_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        done_d       = '0;
`ifdef LLC_ARB_TIMEOUT_EN
        err_d        = '0;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    g_d          = grant_idx;
                    op_wr_d      = cl_wr_req[grant_idx];
                    last_grant_d = grant_idx;
                    wr_req_d     = cl_wr_req[grant_idx];
                    rd_req_d     = ~cl_wr_req[grant_idx];
                    addr_d       = grant_idx ? cl_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                             : cl_addr[ADDR_WIDTH-1:0];
                    wdata_d      = grant_idx ? cl_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                             : cl_wdata[DATA_WIDTH-1:0];
`ifdef LLC_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            ISSUE: begin
                if (done_hit) begin
                    done_d[g_q] = 1'b1;
                    rd_req_d    = 1'b0;
                    wr_req_d    = 1'b0;
                    if (!op_wr_q) rdata_d = read_data;
                end else if (timeout_hit) begin
`ifdef LLC_ARB_TIMEOUT_EN
                    err_d[g_q]  = 1'b1;
`endif
                    rd_req_d    = 1'b0;
                    wr_req_d    = 1'b0;
                end else begin
`ifdef LLC_ARB_TIMEOUT_EN
                    cnt_d       = cnt_q + 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_q          <= 1'b0;
            op_wr_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            done_q       <= '0;
        end else begin
            g_q          <= g_d;
            op_wr_q      <= op_wr_d;
            last_grant_q <= last_grant_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
        end
    end

`ifdef LLC_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign cl_err = err_q;
`else
    assign cl_err = '0;
`endif

    assign busy          = (state_q != IDLE);
    assign cl_done       = done_q;
    assign cl_rdata      = rdata_q;
    assign read_request  = rd_req_q;
    assign write_request = wr_req_q;
    assign write_address = addr_q;
    assign write_data    = wdata_q;

endmodule

// File: doc/llc_req_arbiter.md
Name: llc_req_arbiter

Overview:
- Sits directly upstream of the AXI4-Lite top and drives its LLC-side request port.
- Arbitrates two requesters onto that single read/write port: client 0 is the CPU LLC, client 1 is the USB host DMA engine.
- Round-robin grant; one outstanding transaction at a time. Holds the request level until completion, then returns data and a done pulse to the granted client.

Parameters:
- DATA_WIDTH, 64, data width of client and downstream buses
- ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 1024, abort threshold in cycles; used only with the optional feature

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cl_rd_req  in  2  per-client read request level; bit i = client i
- cl_wr_req  in  2  per-client write request level
- cl_addr  in  2 x ADDR_WIDTH  per-client address
- cl_wdata  in  2 x DATA_WIDTH  per-client write data
- cl_rdata  out  DATA_WIDTH  read data; valid only in the cycle cl_done[g] is high
- cl_done  out  2  one-cycle completion pulse, bit g = granted client
- cl_err  out  2  one-cycle timeout-abort pulse (optional feature only; otherwise tied 0)
- busy  out  1  high while not IDLE
- read_request  out  1  downstream read request level
- write_request  out  1  downstream write request level
- write_address  out  ADDR_WIDTH  downstream request address, used for both reads and writes
- write_data  out  DATA_WIDTH  downstream write data
- read_data  in  DATA_WIDTH  downstream read data
- axi_valid  in  1  downstream read-complete strobe
- axi_ready  in  1  downstream write-complete strobe

Behaviour:
- Reset (rst=0, async): every output is 0. State = IDLE. last_grant = 1, so client 0 wins the first tie.
- Client request:
  - Client raises cl_rd_req or cl_wr_req with addr/wdata stable.
  - It holds the request until its cl_done or cl_err pulse.
  - If a client raises both, the write is served first.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - A client is pending if cl_rd_req|cl_wr_req is set.
  - One pending client: grant it.
  - Both pending: grant the client that is not last_grant.
  - On grant, register g, op, addr and wdata, update last_grant, go to ISSUE.
  - A request sampled at cycle N drives read_request/write_request high at N+1. All downstream outputs are registered.
- ISSUE:
  - The request level and write_address/write_data are held constant.
  - For a read, completion is axi_valid=1: capture read_data into cl_rdata.
  - For a write, completion is axi_ready=1.
  - The strobe of the other type is ignored.
  - Completion at cycle M gives: cl_done[g]=1 at M+1, request levels 0 at M+1, state DONE at M+1.
- DONE: lasts exactly 1 cycle, then IDLE at M+2. The earliest next request assertion is M+3.
  - This guarantees the request deasserts for at least 2 cycles between transactions.
- Stray strobes: axi_valid/axi_ready in IDLE or DONE are ignored with no side effect.
- Client withdraws mid-transaction: the transaction still completes and cl_done still pulses. Clients must not withdraw.
- Requests from the non-granted client while busy: held pending, not dropped. They are served next via round-robin.
- cl_rdata: holds its last captured value outside done pulses. A write completion does not update it.
- busy = (state != IDLE).
- Reset asserted mid-transaction: immediate return to the reset state. The downstream request drops asynchronously and no done pulse is produced.

Optional Feature:
- Macro: LLC_ARB_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES)+1 bits clears on ISSUE entry and increments each ISSUE cycle.
  - When it reaches TIMEOUT_CYCLES with no completion, the next cycle gives cl_err[g]=1, no cl_done, request levels 0, state DONE.
  - A completion in the same cycle as the threshold wins (done, not err).
- Not defined: no counter exists, cl_err is tied to 0, and ISSUE waits indefinitely.

Test Plan:
- Reset then client0 read of addr 0x1000; downstream asserts axi_valid 5 cycles after read_request with read_data 0xDEADBEEF_CAFEF00D -> read_request high 1 cycle after request, cl_done=2'b01 one cycle after axi_valid, cl_rdata=0xDEADBEEF_CAFEF00D, busy low 2 cycles after completion.
- Both clients write simultaneously, repeated 4 times -> grants alternate 0,1,0,1; write_address/write_data match the granted client; each transaction is separated by at least 2 cycles with request low.
- Client1 asserts rd and wr together for addr 0x20 -> write issued first, then read; two cl_done[1] pulses in order.
- During a read, pulse axi_ready, and pulse axi_valid while IDLE -> both ignored; completion occurs only on axi_valid during ISSUE.
- Drop rst for 1 cycle mid-ISSUE -> read_request/write_request 0 immediately, no cl_done; after release, client0 wins a simultaneous tie.
- LLC_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, no completion strobe -> cl_err[g] pulses exactly 17 cycles after ISSUE entry; next request is served normally.
